// File: rtl/labs_pkg.sv
// -----------------------------------------------------------------------------
// labs_pkg
// Shared definitions for the LABS (low-autocorrelation binary sequence) search
// unit: FSM state encoding, the worst-case energy helper and the C_k width.
// -----------------------------------------------------------------------------
package labs_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCorr,
        StCmp,
        StDone
    } labs_state_e;

    // Largest possible sidelobe energy for length n: sum of (n-k)^2, k=1..n-1.
    function automatic int unsigned labs_emax(input int unsigned n);
        return ((n - 1) * n * (2 * n - 1)) / 6;
    endfunction

    // Signed width that holds any C_k for length n (|C_k| <= n-1).
    function automatic int unsigned labs_ck_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/labs_autocorr.sv
// -----------------------------------------------------------------------------
// labs_autocorr
// Purely combinational aperiodic autocorrelation of one candidate at one lag.
// Bit value 0 maps to +1 and 1 maps to -1, so each agreeing pair contributes +1
// and each disagreeing pair -1: C_k = (N-k) - 2*popcount(disagreements).
//
// Ports:
//   cand  in  SEQ_WIDTH  candidate sequence, bit i = s_i
//   k     in  K_WIDTH    lag, 1..SEQ_WIDTH-1
//   ck    out CK_WIDTH   signed C_k
// -----------------------------------------------------------------------------
module labs_autocorr
    import labs_pkg::*;
#(
    parameter int unsigned SEQ_WIDTH = 8,
    parameter int unsigned K_WIDTH   = $clog2(SEQ_WIDTH),
    parameter int unsigned CK_WIDTH  = labs_ck_width(SEQ_WIDTH)
) (
    input  logic        [SEQ_WIDTH-1:0] cand,
    input  logic        [K_WIDTH-1:0]   k,
    output logic signed [CK_WIDTH-1:0]  ck
);

    logic [SEQ_WIDTH-1:0] diff;
    logic [CK_WIDTH-1:0]  pop;
    logic [CK_WIDTH-1:0]  n_minus_k;

    // Only the low N-k bits compare real pairs; the shifted-in zeros are masked.
    assign diff      = (cand ^ (cand >> k)) & ({SEQ_WIDTH{1'b1}} >> k);
    assign n_minus_k = CK_WIDTH'(SEQ_WIDTH) - CK_WIDTH'(k);

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(SEQ_WIDTH); i++) begin
            pop = pop + {{(CK_WIDTH - 1){1'b0}}, diff[i]};
        end
    end

    // Modular arithmetic in CK_WIDTH bits; the true result always fits.
    assign ck = $signed(n_minus_k - (pop << 1));

endmodule

// File: rtl/labs_search_unit.sv
// -----------------------------------------------------------------------------
// labs_search_unit
// Exhaustive LABS search over this unit's share of the candidates
// UNIT_INDEX, UNIT_INDEX+N_UNITS, ... <= 2^(N-1)-1 (MSB fixed at 0 by
// complement symmetry). Each candidate takes N+1 enabled cycles: LOAD, N-1
// CORR lags, CMP. The running minimum is kept with a strict compare so the
// earliest minimum-energy candidate wins.
//
// Ports:
//   i_clk    in   1          clock
//   i_rst_n  in   1          asynchronous active-low reset
//   i_en     in   1          run enable; low freezes all state
//   o_seq    out  SEQ_WIDTH  best sequence so far (reset 0)
//   o_e      out  E_WIDTH    energy of o_seq, saturating (reset all-ones)
//   o_done   out  1          sticky search-complete flag (reset 0)
// -----------------------------------------------------------------------------
module labs_search_unit
    import labs_pkg::*;
#(
    parameter int unsigned SEQ_WIDTH  = 8,
    parameter int unsigned E_WIDTH    = 16,
    parameter int unsigned N_UNITS    = 4,
    parameter int unsigned UNIT_INDEX = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    output logic [SEQ_WIDTH-1:0] o_seq,
    output logic [E_WIDTH-1:0]   o_e,
    output logic                 o_done
);

    localparam int unsigned CW = labs_ck_width(SEQ_WIDTH);
    localparam int unsigned KW = $clog2(SEQ_WIDTH);
    localparam int unsigned SQ = 2 * CW;
    localparam int unsigned SW = ((E_WIDTH > SQ) ? E_WIDTH : SQ) + 1;

    localparam logic [SEQ_WIDTH:0] LAST_CAND = {2'b00, {(SEQ_WIDTH - 1){1'b1}}};
    localparam logic [SEQ_WIDTH:0] STRIDE    = (SEQ_WIDTH + 1)'(N_UNITS);

    // Undersized E_WIDTH is legal (energies saturate), so only report it.
    if (E_WIDTH < $clog2(labs_emax(SEQ_WIDTH) + 1)) begin : g_ewidth_note
        $info("labs_search_unit: E_WIDTH=%0d below %0d, large energies will saturate",
              E_WIDTH, $clog2(labs_emax(SEQ_WIDTH) + 1));
    end

    labs_state_e          state_q;
    logic [KW-1:0]        k_q;
    logic [E_WIDTH-1:0]   acc_q;
    logic [SEQ_WIDTH-1:0] cand_q;
    logic [SEQ_WIDTH-1:0] next_q;

    logic signed [CW-1:0] ck;
    logic [CW-1:0]        ck_u;
    logic [CW-1:0]        ck_mag;
    logic [SQ-1:0]        ck_sq;
    logic [SW-1:0]        acc_sum;
    logic [E_WIDTH-1:0]   acc_sat;
    logic [SEQ_WIDTH:0]   cand_sum;
    logic                 is_last;

    labs_autocorr #(
        .SEQ_WIDTH (SEQ_WIDTH),
        .K_WIDTH   (KW),
        .CK_WIDTH  (CW)
    ) u_autocorr (
        .cand (cand_q),
        .k    (k_q),
        .ck   (ck)
    );

    // |C_k|; the most negative code maps to its correct unsigned magnitude.
    assign ck_u    = ck;
    assign ck_mag  = ck_u[CW-1] ? (~ck_u + CW'(1)) : ck_u;
    assign ck_sq   = SQ'(ck_mag) * SQ'(ck_mag);
    assign acc_sum = SW'(acc_q) + SW'(ck_sq);
    assign acc_sat = (acc_sum[SW-1:E_WIDTH] != '0) ? {E_WIDTH{1'b1}} : acc_sum[E_WIDTH-1:0];

    // One extra bit so the stride past the last candidate cannot wrap.
    assign cand_sum = {1'b0, cand_q} + STRIDE;
    assign is_last  = (cand_sum > LAST_CAND);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            acc_q   <= '0;
            cand_q  <= '0;
            next_q  <= SEQ_WIDTH'(UNIT_INDEX);
            o_seq   <= '0;
            o_e     <= '1;
            o_done  <= 1'b0;
        end else if (i_en) begin
            case (state_q)
                StIdle: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    cand_q  <= next_q;
                    acc_q   <= '0;
                    k_q     <= KW'(1);
                    state_q <= StCorr;
                end
                StCorr: begin
                    acc_q <= acc_sat;
                    k_q   <= k_q + KW'(1);
                    if (k_q == KW'(SEQ_WIDTH - 1)) begin
                        state_q <= StCmp;
                    end
                end
                StCmp: begin
                    if (acc_q < o_e) begin
                        o_seq <= cand_q;
                        o_e   <= acc_q;
                    end
                    if (is_last) begin
                        o_done  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        next_q  <= cand_sum[SEQ_WIDTH-1:0];
                        state_q <= StLoad;
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_labs_search_unit.sv
// -----------------------------------------------------------------------------
// tb_labs_search_unit
// Directed bench: several search units with different parameters run side by
// side from a shared clock; edges are counted from the first enabled edge.
// -----------------------------------------------------------------------------
module tb_labs_search_unit;

    logic clk;
    logic rst_n;
    logic rst_r;
    logic en_a, en_b, en_c, en_sat, en_s, en_r;

    logic [3:0]  seq_a, seq_b, seq_s, seq_r;
    logic [15:0] e_a, e_b, e_s, e_r;
    logic        done_a, done_b, done_s, done_r;
    logic [7:0]  seq_c [4];
    logic [15:0] e_c [4];
    logic        done_c [4];
    logic [7:0]  seq_sat;
    logic [6:0]  e_sat;
    logic        done_sat;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baseline N=4 single unit.
    labs_search_unit #(.SEQ_WIDTH(4), .E_WIDTH(16), .N_UNITS(1), .UNIT_INDEX(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .o_seq(seq_a), .o_e(e_a), .o_done(done_a)
    );

    // N=4, odd candidates only.
    labs_search_unit #(.SEQ_WIDTH(4), .E_WIDTH(16), .N_UNITS(2), .UNIT_INDEX(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .o_seq(seq_b), .o_e(e_b), .o_done(done_b)
    );

    // N=4 with a stall in the middle.
    labs_search_unit #(.SEQ_WIDTH(4), .E_WIDTH(16), .N_UNITS(1), .UNIT_INDEX(0)) u_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_s), .o_seq(seq_s), .o_e(e_s), .o_done(done_s)
    );

    // N=4 with its own reset pulsed mid-search.
    labs_search_unit #(.SEQ_WIDTH(4), .E_WIDTH(16), .N_UNITS(1), .UNIT_INDEX(0)) u_r (
        .i_clk(clk), .i_rst_n(rst_r), .i_en(en_r), .o_seq(seq_r), .o_e(e_r), .o_done(done_r)
    );

    // N=8 with a 7-bit saturating energy.
    labs_search_unit #(.SEQ_WIDTH(8), .E_WIDTH(7), .N_UNITS(1), .UNIT_INDEX(0)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_sat),
        .o_seq(seq_sat), .o_e(e_sat), .o_done(done_sat)
    );

    // N=8 split over four concurrent units.
    for (genvar g = 0; g < 4; g++) begin : g_c
        labs_search_unit #(.SEQ_WIDTH(8), .E_WIDTH(16), .N_UNITS(4), .UNIT_INDEX(g)) u_c (
            .i_clk(clk), .i_rst_n(rst_n), .i_en(en_c),
            .o_seq(seq_c[g]), .o_e(e_c[g]), .o_done(done_c[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] min_c();
        logic [15:0] m;
        m = e_c[0];
        for (int i = 1; i < 4; i++) begin
            if (e_c[i] < m) m = e_c[i];
        end
        return m;
    endfunction

    initial begin
        rst_n  = 1'b0;
        rst_r  = 1'b0;
        en_a   = 1'b0;
        en_b   = 1'b0;
        en_c   = 1'b0;
        en_sat = 1'b0;
        en_s   = 1'b0;
        en_r   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_seq_a",   32'(seq_a),   32'h0);
        check_eq("reset_e_a",     32'(e_a),     32'hffff);
        check_eq("reset_done_a",  32'(done_a),  32'h0);
        check_eq("reset_e_sat",   32'(e_sat),   32'h7f);
        check_eq("reset_seq_c3",  32'(seq_c[3]), 32'h0);

        @(negedge clk);
        rst_n  = 1'b1;
        rst_r  = 1'b1;
        en_a   = 1'b1;
        en_b   = 1'b1;
        en_c   = 1'b1;
        en_sat = 1'b1;
        en_s   = 1'b1;
        en_r   = 1'b1;

        for (int e = 1; e <= 1200; e++) begin
            @(posedge clk);
            #1;
            // Baseline: candidate 0 (E=14) lands at edge 6, best is 0001/E=2.
            if (e == 5)  check_eq("a_e_before_cmp0", 32'(e_a), 32'hffff);
            if (e == 6)  check_eq("a_e_after_cmp0",  32'(e_a), 32'd14);
            if (e == 40) check_eq("a_done_early",    32'(done_a), 32'h0);
            if (e == 41) begin
                check_eq("a_done",  32'(done_a), 32'h1);
                check_eq("a_seq",   32'(seq_a),  32'h1);
                check_eq("a_e",     32'(e_a),    32'd2);
            end
            // Odd candidates 1,3,5,7.
            if (e == 20) check_eq("b_done_early", 32'(done_b), 32'h0);
            if (e == 21) begin
                check_eq("b_done", 32'(done_b), 32'h1);
                check_eq("b_seq",  32'(seq_b),  32'h1);
                check_eq("b_e",    32'(e_b),    32'd2);
            end
            // Stall: edges 14..18 disabled while in CORR of candidate 2.
            if (e == 13) en_s = 1'b0;
            if (e == 18) en_s = 1'b1;
            if (e == 45) check_eq("s_done_early", 32'(done_s), 32'h0);
            if (e == 46) begin
                check_eq("s_done", 32'(done_s), 32'h1);
                check_eq("s_seq",  32'(seq_s),  32'h1);
                check_eq("s_e",    32'(e_s),    32'd2);
            end
            // Asynchronous reset mid-CORR of candidate 2, released after edge 20.
            if (e == 13) begin
                check_eq("r_e_before_reset", 32'(e_r), 32'd2);
                #1;
                rst_r = 1'b0;
                #1;
                check_eq("r_async_seq",  32'(seq_r),  32'h0);
                check_eq("r_async_e",    32'(e_r),    32'hffff);
                check_eq("r_async_done", 32'(done_r), 32'h0);
            end
            if (e == 20) rst_r = 1'b1;
            if (e == 60) check_eq("r_done_early", 32'(done_r), 32'h0);
            if (e == 61) begin
                check_eq("r_done", 32'(done_r), 32'h1);
                check_eq("r_seq",  32'(seq_r),  32'h1);
                check_eq("r_e",    32'(e_r),    32'd2);
            end
            // Four-way N=8 split: 32 candidates each.
            if (e == 288) begin
                for (int i = 0; i < 4; i++) check_eq("c_done_early", 32'(done_c[i]), 32'h0);
            end
            if (e == 289) begin
                for (int i = 0; i < 4; i++) check_eq("c_done", 32'(done_c[i]), 32'h1);
                check_eq("c_min_e", 32'(min_c()), 32'd8);
            end
            // Saturation: candidate 0 has E=140, clipped to 127.
            if (e == 10) begin
                check_eq("sat_e_first_cmp",   32'(e_sat),   32'h7f);
                check_eq("sat_seq_first_cmp", 32'(seq_sat), 32'h0);
            end
            if (e == 1152) check_eq("sat_done_early", 32'(done_sat), 32'h0);
            if (e == 1153) begin
                check_eq("sat_done", 32'(done_sat), 32'h1);
                check_eq("sat_e",    32'(e_sat),    32'd8);
            end
        end

        // Results must hold long after completion.
        check_eq("a_seq_hold",  32'(seq_a),  32'h1);
        check_eq("a_e_hold",    32'(e_a),    32'd2);
        check_eq("a_done_hold", 32'(done_a), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
